mem_write_monitor: RTL and testbench

- Passive observer on the processor-to-data-memory bus. Reads the sel/wen/addr/wdata stream that the processor drives as its data-access initiator.
- Counts loads and stores, keeps a rolling store signature, and logs stores into a small FIFO.
- Detects the program-exit store (wdata == EXIT_WORD), waits a drain window, then flags completion. A run with no exit store ends on a cycle timeout.
- Sits next to the data memory instance in the processor/FPU harness. It replaces the ad-hoc exit detection in the testbench.

---
 rtl/mem_write_monitor.sv | 218 +++++++++++++++++++++
 tb/tb_mem_write_monitor.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_monitor.sv
// Passive data-bus monitor: counts loads/stores, keeps a rolling store signature,
// logs stores into a show-ahead FIFO and flags completion on exit store or timeout.
module mem_write_monitor #(
    parameter int unsigned       ADDR_W         = 32,
    parameter int unsigned       DATA_W         = 32,
    parameter logic [DATA_W-1:0] EXIT_WORD      = {DATA_W{1'b1}},
    parameter int unsigned       DRAIN_CYCLES   = 10,
    parameter int unsigned       TIMEOUT_CYCLES = 60,
    parameter int unsigned       LOG_DEPTH      = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              sel,
    input  logic              wen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              log_pop,
    output logic              log_valid,
    output logic [ADDR_W-1:0] log_addr,
    output logic [DATA_W-1:0] log_data,
    output logic              log_overflow,
    output logic [15:0]       store_count,
    output logic [15:0]       load_count,
    output logic [31:0]       signature,
    output logic [1:0]        state,
    output logic              done,
    output logic              timed_out
);

    localparam int unsigned PTR_W = $clog2(LOG_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned CYC_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned DRN_W = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CYC_W-1:0]   r_cycle_cnt;
    logic [DRN_W-1:0]   r_drain_cnt;
    logic               r_done;
    logic               r_timed_out;
    logic [15:0]        r_store_count;
    logic [15:0]        r_load_count;
    logic [31:0]        r_signature;

    logic [ADDR_W-1:0]  r_mem_addr [LOG_DEPTH];
    logic [DATA_W-1:0]  r_mem_data [LOG_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;

    logic               w_arm;
    logic               w_capture;
    logic               w_cap_store;
    logic               w_cap_load;
    logic               w_exit;
    logic               w_timeout;
    logic               w_drain_end;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic [31:0]        w_sig_nxt;

    // Bus decode; captures only happen while the run is live.
    assign w_arm       = start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
    assign w_capture   = (r_state == ST_RUN) | (r_state == ST_DRAIN);
    assign w_cap_store = w_capture & sel & wen;
    assign w_cap_load  = w_capture & sel & ~wen;
    assign w_exit      = (r_state == ST_RUN) & w_cap_store & (wdata == EXIT_WORD);
    assign w_timeout   = (r_state == ST_RUN) & (r_cycle_cnt == CYC_W'(TIMEOUT_CYCLES - 1));
    assign w_drain_end = (r_state == ST_DRAIN) & (r_drain_cnt == '0);
    assign w_sig_nxt   = {r_signature[30:0], r_signature[31]} ^ 32'(addr) ^ 32'(wdata);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; an exit store takes priority over a same-edge timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (w_exit) begin
                    w_state_nxt = ST_DRAIN;
                end else if (w_timeout) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DRAIN: if (w_drain_end) w_state_nxt = ST_DONE;
            ST_DONE:  if (start) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Run-cycle and drain counters plus the sticky completion flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cycle_cnt <= '0;
            r_drain_cnt <= '0;
            r_done      <= 1'b0;
            r_timed_out <= 1'b0;
        end else if (w_arm) begin
            r_cycle_cnt <= '0;
            r_drain_cnt <= '0;
            r_done      <= 1'b0;
            r_timed_out <= 1'b0;
        end else begin
            if (r_state == ST_RUN) begin
                r_cycle_cnt <= r_cycle_cnt + CYC_W'(1);
            end
            if (w_exit) begin
                r_drain_cnt <= DRN_W'(DRAIN_CYCLES - 1);
            end else if ((r_state == ST_DRAIN) && (r_drain_cnt != '0)) begin
                r_drain_cnt <= r_drain_cnt - DRN_W'(1);
            end
            if (w_timeout && !w_exit) begin
                r_done      <= 1'b1;
                r_timed_out <= 1'b1;
            end else if (w_drain_end) begin
                r_done      <= 1'b1;
            end
        end
    end

    // Saturating access counters and rolling store signature.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_store_count <= '0;
            r_load_count  <= '0;
            r_signature   <= '0;
        end else if (w_arm) begin
            r_store_count <= '0;
            r_load_count  <= '0;
            r_signature   <= '0;
        end else begin
            if (w_cap_store) begin
                if (r_store_count != 16'hFFFF) begin
                    r_store_count <= r_store_count + 16'd1;
                end
                r_signature <= w_sig_nxt;
            end
            if (w_cap_load && (r_load_count != 16'hFFFF)) begin
                r_load_count <= r_load_count + 16'd1;
            end
        end
    end

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_full  = (r_count == CNT_W'(LOG_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = log_pop & ~w_empty & ~w_arm;
    assign w_push  = w_cap_store & (~w_full | w_pop);
    assign w_drop  = w_cap_store & w_full & ~w_pop;

    // Store log storage and pointers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < int'(LOG_DEPTH); i++) begin
                r_mem_addr[i] <= '0;
                r_mem_data[i] <= '0;
            end
        end else if (w_arm) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem_addr[r_wr_ptr] <= addr;
                r_mem_data[r_wr_ptr] <= wdata;
                r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign log_valid    = ~w_empty;
    assign log_addr     = r_mem_addr[r_rd_ptr];
    assign log_data     = r_mem_data[r_rd_ptr];
    assign log_overflow = r_overflow;
    assign store_count  = r_store_count;
    assign load_count   = r_load_count;
    assign signature    = r_signature;
    assign state        = r_state;
    assign done         = r_done;
    assign timed_out    = r_timed_out;

endmodule

// File: tb/tb_mem_write_monitor.sv
// Directed self-checking bench for mem_write_monitor.
module tb_mem_write_monitor;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        sel = 1'b0;
    logic        wen = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        log_pop = 1'b0;
    logic        log_valid;
    logic [31:0] log_addr;
    logic [31:0] log_data;
    logic        log_overflow;
    logic [15:0] store_count;
    logic [15:0] load_count;
    logic [31:0] signature;
    logic [1:0]  state;
    logic        done;
    logic        timed_out;

    int vectors = 0;
    int miscompares = 0;

    mem_write_monitor #(
        .ADDR_W(32), .DATA_W(32), .EXIT_WORD(32'hFFFFFFFF),
        .DRAIN_CYCLES(10), .TIMEOUT_CYCLES(60), .LOG_DEPTH(8)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .sel(sel), .wen(wen),
        .addr(addr), .wdata(wdata), .log_pop(log_pop), .log_valid(log_valid),
        .log_addr(log_addr), .log_data(log_data), .log_overflow(log_overflow),
        .store_count(store_count), .load_count(load_count), .signature(signature),
        .state(state), .done(done), .timed_out(timed_out)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_idle();
        start = 1'b0; sel = 1'b0; wen = 1'b0; addr = '0; wdata = '0; log_pop = 1'b0;
    endtask

    task automatic apply_reset();
        bus_idle();
        #2 reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic pop);
        sel = 1'b1; wen = 1'b1; addr = a; wdata = d; log_pop = pop;
        tick();
        bus_idle();
    endtask

    task automatic do_pop();
        log_pop = 1'b1;
        tick();
        log_pop = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL reset_state got %0d exp 0", state); end
        vectors++; if ({log_valid, log_addr, log_data, log_overflow, store_count, load_count, signature, done, timed_out} !== '0) begin
            miscompares++; $display("FAIL reset_outputs got nonzero valid=%b cnt=%h sig=%h done=%b", log_valid, store_count, signature, done);
        end
        tick();
        reset = 1'b0;
        sel = 1'b1; wen = 1'b1; addr = 32'h4; wdata = 32'h5;
        tick();
        bus_idle();
        vectors++; if (store_count !== 16'd0) begin miscompares++; $display("FAIL idle_ignore got %0d exp 0", store_count); end
        vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL idle_state got %0d exp 0", state); end
    endtask

    task automatic test_stores();
        logic [31:0] exp_a [3];
        logic [31:0] exp_d [3];
        exp_a[0] = 32'h4; exp_a[1] = 32'h8;  exp_a[2] = 32'hC;
        exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33;
        apply_reset();
        do_start();
        vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL start_state got %0d exp 1", state); end
        for (int i = 0; i < 3; i++) do_store(exp_a[i], exp_d[i], 1'b0);
        vectors++; if (store_count !== 16'd3) begin miscompares++; $display("FAIL store_count got %0d exp 3", store_count); end
        vectors++; if (signature !== 32'h0000003F) begin miscompares++; $display("FAIL signature got %h exp 0000003f", signature); end
        for (int i = 0; i < 3; i++) begin
            vectors++; if (log_valid !== 1'b1 || log_addr !== exp_a[i] || log_data !== exp_d[i]) begin
                miscompares++; $display("FAIL pop%0d got v=%b %h/%h exp 1 %h/%h", i, log_valid, log_addr, log_data, exp_a[i], exp_d[i]);
            end
            do_pop();
        end
        vectors++; if (log_valid !== 1'b0) begin miscompares++; $display("FAIL empty_after_pops got %b exp 0", log_valid); end
    endtask

    task automatic test_exit_drain();
        apply_reset();
        do_start();
        do_store(32'h10, 32'hFFFFFFFF, 1'b0);
        vectors++; if (state !== 2'd2) begin miscompares++; $display("FAIL exit_to_drain got %0d exp 2", state); end
        for (int i = 0; i < 9; i++) tick();
        vectors++; if (state !== 2'd2 || done !== 1'b0) begin miscompares++; $display("FAIL drain_e9 got st=%0d done=%b exp 2/0", state, done); end
        tick();
        vectors++; if (state !== 2'd3 || done !== 1'b1) begin miscompares++; $display("FAIL drain_e10 got st=%0d done=%b exp 3/1", state, done); end
        vectors++; if (timed_out !== 1'b0) begin miscompares++; $display("FAIL exit_timed_out got %b exp 0", timed_out); end
        vectors++; if (store_count !== 16'd1) begin miscompares++; $display("FAIL exit_store_count got %0d exp 1", store_count); end
        do_store(32'h20, 32'h5, 1'b0);
        vectors++; if (store_count !== 16'd1) begin miscompares++; $display("FAIL done_no_capture got %0d exp 1", store_count); end
    endtask

    task automatic test_timeout();
        apply_reset();
        do_start();
        for (int i = 0; i < 59; i++) tick();
        vectors++; if (state !== 2'd1 || done !== 1'b0) begin miscompares++; $display("FAIL pre_timeout got st=%0d done=%b exp 1/0", state, done); end
        tick();
        vectors++; if (state !== 2'd3 || done !== 1'b1 || timed_out !== 1'b1) begin
            miscompares++; $display("FAIL timeout got st=%0d done=%b to=%b exp 3/1/1", state, done, timed_out);
        end
        vectors++; if (store_count !== 16'd0) begin miscompares++; $display("FAIL timeout_count got %0d exp 0", store_count); end
        do_start();
        vectors++; if (state !== 2'd1 || done !== 1'b0 || timed_out !== 1'b0) begin
            miscompares++; $display("FAIL rearm got st=%0d done=%b to=%b exp 1/0/0", state, done, timed_out);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        do_start();
        for (int i = 0; i < 9; i++) do_store(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0);
        vectors++; if (store_count !== 16'd9) begin miscompares++; $display("FAIL ovf_count got %0d exp 9", store_count); end
        vectors++; if (log_overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got %b exp 1", log_overflow); end
        for (int i = 0; i < 8; i++) begin
            vectors++; if (log_valid !== 1'b1 || log_addr !== 32'h100 + 32'(4 * i) || log_data !== 32'hA0 + 32'(i)) begin
                miscompares++; $display("FAIL ovf_pop%0d got v=%b %h/%h exp 1 %h/%h", i, log_valid, log_addr, log_data,
                                        32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
            end
            do_pop();
        end
        vectors++; if (log_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_ninth_lost got %b exp 0", log_valid); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        do_start();
        for (int i = 0; i < 8; i++) do_store(32'h200 + 32'(i), 32'hB0 + 32'(i), 1'b0);
        do_store(32'h208, 32'hB8, 1'b1);
        vectors++; if (log_overflow !== 1'b0) begin miscompares++; $display("FAIL full_pushpop_ovf got %b exp 0", log_overflow); end
        for (int i = 1; i < 9; i++) begin
            vectors++; if (log_valid !== 1'b1 || log_data !== 32'hB0 + 32'(i)) begin
                miscompares++; $display("FAIL b2b_pop%0d got v=%b %h exp 1 %h", i, log_valid, log_data, 32'hB0 + 32'(i));
            end
            do_pop();
        end
        vectors++; if (log_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_empty got %b exp 0", log_valid); end
        do_pop();
        vectors++; if (log_valid !== 1'b0) begin miscompares++; $display("FAIL pop_empty got %b exp 0", log_valid); end
    endtask

    task automatic test_loads();
        apply_reset();
        do_start();
        for (int i = 0; i < 5; i++) begin
            sel = 1'b1; wen = 1'b0; addr = 32'h40 + 32'(i); wdata = 32'h77;
            tick();
        end
        bus_idle();
        vectors++; if (load_count !== 16'd5) begin miscompares++; $display("FAIL load_count got %0d exp 5", load_count); end
        vectors++; if (store_count !== 16'd0 || log_valid !== 1'b0 || signature !== 32'd0) begin
            miscompares++; $display("FAIL loads_side got sc=%0d v=%b sig=%h exp 0/0/0", store_count, log_valid, signature);
        end
    endtask

    task automatic test_reset_in_drain();
        apply_reset();
        do_start();
        do_store(32'h10, 32'hFFFFFFFF, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        vectors++; if (state !== 2'd2 || log_valid !== 1'b1) begin miscompares++; $display("FAIL pre_abort got st=%0d v=%b exp 2/1", state, log_valid); end
        reset = 1'b1;
        #1;
        vectors++; if ({log_valid, log_addr, log_data, log_overflow, store_count, load_count, signature, state, done, timed_out} !== '0) begin
            miscompares++; $display("FAIL async_abort got st=%0d sc=%0d v=%b sig=%h exp all 0", state, store_count, log_valid, signature);
        end
        #1 reset = 1'b0;
        do_store(32'h30, 32'h3, 1'b0);
        do_store(32'h34, 32'h4, 1'b0);
        vectors++; if (store_count !== 16'd0 || state !== 2'd0 || log_valid !== 1'b0) begin
            miscompares++; $display("FAIL post_abort got sc=%0d st=%0d v=%b exp 0/0/0", store_count, state, log_valid);
        end
        do_start();
        do_store(32'h38, 32'h8, 1'b0);
        vectors++; if (store_count !== 16'd1 || signature !== 32'h30) begin
            miscompares++; $display("FAIL restart_store got sc=%0d sig=%h exp 1/00000030", store_count, signature);
        end
    endtask

    initial begin
        test_reset();
        test_stores();
        test_exit_drain();
        test_timeout();
        test_overflow();
        test_back_to_back();
        test_loads();
        test_reset_in_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
